// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// The CPU's halt detection compares against the same HALT_WORD.
package imem_loader_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        S_HI   = 3'd0,
        S_LO   = 3'd1,
        S_WR   = 3'd2,
        S_CK   = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Boot-link byte stream plus instruction-memory write port.
// Handshake: a byte moves on a rising edge only when in_valid and in_ready
// are both high; in_ready never depends combinationally on in_valid.
// master = the loader (accepts bytes, drives the write port);
// slave  = the environment (boot link source and memory).
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic                                 in_valid;
    logic [7:0]                           in_data;
    logic                                 in_ready;
    logic                                 we;
    logic [ADDR_W-1:0]                    waddr;
    logic [imem_loader_pkg::INSTR_W-1:0]  wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader_byte_pack.sv
// byte_pack: assembles big-endian 16-bit words from the byte stream.
// Holds the high byte; the completed word is {hi, current byte} and is
// only meaningful in the cycle word_fire_o is high.
module byte_pack
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ready_i,
    input  logic               valid_i,
    input  logic [7:0]         data_i,
    input  logic               hi_sel_i,
    input  logic               lo_sel_i,
    output logic               hi_fire_o,
    output logic               word_fire_o,
    output logic [INSTR_W-1:0] word_o
);

    logic       fire;
    logic [7:0] hi_q;
    logic [7:0] hi_d;

    assign fire        = valid_i & ready_i;
    assign hi_fire_o   = fire & hi_sel_i;
    assign word_fire_o = fire & lo_sel_i;
    assign word_o      = {hi_q, data_i};

    // Capture the high byte when it is transferred.
    always_comb begin
        hi_d = hi_q;
        if (hi_fire_o) begin
            hi_d = data_i;
        end
    end

    // High-byte register; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= 8'h00;
        end else begin
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the CPU instruction memory.
// Streams big-endian words into consecutive addresses from 0, holds the
// CPU stalled until the halt word is written, flags overflow.
// Optional feature macro: IMEM_LOADER_CKSUM_EN adds a trailing XOR
// checksum byte after the halt word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loader_if.master  bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           cpu_run,
    output state_e         dbg_state_o
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [INSTR_W-1:0]   wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 hi_fire;
    logic                 word_fire;
    logic [INSTR_W-1:0]   word;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]           xsum_q, xsum_d;
    logic                 ck_fire;

    assign ck_fire = bus.in_valid & in_ready_q;
`endif

    byte_pack u_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready_i     (in_ready_q),
        .valid_i     (bus.in_valid),
        .data_i      (bus.in_data),
        .hi_sel_i    (state_q == S_HI),
        .lo_sel_i    (state_q == S_LO),
        .hi_fire_o   (hi_fire),
        .word_fire_o (word_fire),
        .word_o      (word)
    );

    // Next state, address advance and error detection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            S_HI: begin
                if (hi_fire) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (word_fire) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (wdata_q == HALT_WORD) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    state_d = S_CK;
`else
                    state_d = S_DONE;
`endif
                end else if (addr_q == ADDR_MAX) begin
                    // Last slot used by a non-halt word: nowhere left for the halt.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_HI;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CK: begin
                if (ck_fire) begin
                    state_d = S_DONE;
                    if (bus.in_data != xsum_q) begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_HI;
            end
        endcase
    end

    // Registered outputs are computed from the state being entered.
    always_comb begin
        in_ready_d = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_CK);
        we_d       = (state_d == S_WR);
        done_d     = (state_d == S_DONE);
        waddr_d    = word_fire ? addr_q : waddr_q;
        wdata_d    = word_fire ? word : wdata_q;
        busy_d     = busy_q;
        if (state_d == S_DONE) begin
            busy_d = 1'b0;
        end else if (hi_fire) begin
            busy_d = 1'b1;
        end
`ifdef IMEM_LOADER_CKSUM_EN
        xsum_d = xsum_q;
        if (hi_fire || word_fire) begin
            xsum_d = xsum_q ^ bus.in_data;
        end
`endif
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_HI;
            addr_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef IMEM_LOADER_CKSUM_EN
    // Running XOR of every accepted data byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xsum_q <= 8'h00;
        end else begin
            xsum_q <= xsum_d;
        end
    end
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_run      = done_q & ~err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized byte streams checked against a
// word-level reference model. Two instances: ADDR_W=8 and ADDR_W=2.
module tb_imem_loader;
    import imem_loader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic       sel;        // 0: dut_a (ADDR_W=8), 1: dut_b (ADDR_W=2)
    logic       in_valid;
    logic [7:0] in_data;

    imem_loader_if #(.ADDR_W(8)) bus_a ();
    imem_loader_if #(.ADDR_W(2)) bus_b ();

    assign bus_a.in_valid = in_valid & ~sel;
    assign bus_a.in_data  = in_data;
    assign bus_b.in_valid = in_valid & sel;
    assign bus_b.in_data  = in_data;

    logic   busy_a, done_a, err_a, run_a;
    logic   busy_b, done_b, err_b, run_b;
    state_e dbg_a, dbg_b;

    imem_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .busy(busy_a), .done(done_a), .err(err_a), .cpu_run(run_a),
        .dbg_state_o(dbg_a)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .busy(busy_b), .done(done_b), .err(err_b), .cpu_run(run_b),
        .dbg_state_o(dbg_b)
    );

    // Selected-instance view
    logic        in_ready, we, busy, done, err, cpu_run;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    assign in_ready = sel ? bus_b.in_ready : bus_a.in_ready;
    assign we       = sel ? bus_b.we       : bus_a.we;
    assign waddr    = sel ? {6'b0, bus_b.waddr} : bus_a.waddr;
    assign wdata    = sel ? bus_b.wdata    : bus_a.wdata;
    assign busy     = sel ? busy_b : busy_a;
    assign done     = sel ? done_b : done_a;
    assign err      = sel ? err_b  : err_a;
    assign cpu_run  = sel ? run_b  : run_a;

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          we_t[$];
    int          cyc = 0;
    int          ready_in_wr = 0;
    logic        exp_err, exp_done;
    int          n_vec = 0;
    int          n_err = 0;

    // Monitor: collect every write strobe, sampled away from the clock edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (we === 1'b1) begin
            got_q.push_back({waddr, wdata});
            we_t.push_back(cyc);
        end
        if (we === 1'b1 && in_ready === 1'b1) ready_in_wr <= ready_in_wr + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Pairs bytes into big-endian words written from address 0; stops at
    // the halt word (plus checksum byte when enabled) or on overflow.
    task automatic model_load(input logic [7:0] b[$], input int aw);
        logic [15:0] w;
        logic [7:0]  x;
        int          a;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i + 1 < b.size(); i += 2) begin
            w = {b[i], b[i+1]};
            a = i / 2;
            exp_q.push_back({a[7:0], w});
            if (w == 16'hFFFF) begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (b.size() > i + 2) begin
                    x = 8'h00;
                    for (int j = 0; j <= i + 1; j++) x = x ^ b[j];
                    exp_done = 1'b1;
                    exp_err  = (b[i+2] != x);
                end
`else
                exp_done = 1'b1;
`endif
                break;
            end else if (a == (1 << aw) - 1) begin
                exp_err  = 1'b1;
                exp_done = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        we_t.delete();
        ready_in_wr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int n;
        n = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 40);
        if (ok) @(posedge clk);
    endtask

    // Sends a stream, then compares writes and status with the model.
    task automatic run_load(input string name, input logic [7:0] b[$], input int maxgap);
        bit ok;
        model_load(b, sel ? 2 : 8);
        foreach (b[i]) begin
            send_byte(b[i], $urandom_range(0, maxgap), ok);
            if (!ok) begin
                n_vec++; n_err++;
                $display("FAIL %s byte%0d: not accepted within 40 cycles", name, i);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s write_count: got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s write%0d: got addr %h data %h want addr %h data %h",
                         name, i, got_q[i][23:16], got_q[i][15:0], exp_q[i][23:16], exp_q[i][15:0]);
            end
        end
        n_vec++;
        if (done !== exp_done || err !== exp_err || cpu_run !== (exp_done & ~exp_err)) begin
            n_err++;
            $display("FAIL %s status: got done=%b err=%b run=%b want done=%b err=%b run=%b",
                     name, done, err, cpu_run, exp_done, exp_err, exp_done & ~exp_err);
        end
        n_vec++;
        if (busy !== ~exp_done) begin
            n_err++;
            $display("FAIL %s busy: got %b want %b", name, busy, ~exp_done);
        end
        n_vec++;
        if (ready_in_wr !== 0) begin
            n_err++;
            $display("FAIL %s ready_in_wr: got %0d want 0", name, ready_in_wr);
        end
    endtask

    // Appends the XOR checksum byte when that feature is built in.
    task automatic add_cksum(inout logic [7:0] b[$], input bit corrupt);
        logic [7:0] x;
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
`ifdef IMEM_LOADER_CKSUM_EN
        b.push_back(corrupt ? (x ^ 8'h01) : x);
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, we, waddr, wdata, busy, done, err, cpu_run} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b run=%b want all 0",
                     in_ready, we, waddr, wdata, busy, done, err, cpu_run);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_edge: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        sel = 1'b0;
        do_reset();
        b = {8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
        add_cksum(b, 1'b0);
        run_load("basic", b, 0);
        for (int i = 1; i < we_t.size(); i++) begin
            n_vec++;
            if (we_t[i] - we_t[i-1] != 3) begin
                n_err++;
                $display("FAIL basic_spacing%0d: got %0d want 3", i, we_t[i] - we_t[i-1]);
            end
        end
    endtask

    task automatic test_post_done();
        int n_we;
        n_we = got_q.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            n_vec++;
            if (in_ready !== 1'b0 || we !== 1'b0) begin
                n_err++;
                $display("FAIL post_done%0d: got rdy=%b we=%b want 0 0", i, in_ready, we);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (got_q.size() != n_we) begin
            n_err++;
            $display("FAIL post_done_writes: got %0d want %0d", got_q.size(), n_we);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] b[$];
        sel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            b = {8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
            add_cksum(b, 1'b0);
            run_load("gaps", b, 4);
        end
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        logic [15:0] w;
        int k;
        sel = 1'b0;
        for (int t = 0; t < 8; t++) begin
            do_reset();
            b.delete();
            k = $urandom_range(0, 10);
            for (int i = 0; i < k; i++) begin
                w = 16'($urandom_range(0, 16'hFFFE));
                b.push_back(w[15:8]);
                b.push_back(w[7:0]);
            end
            b.push_back(8'hFF);
            b.push_back(8'hFF);
            add_cksum(b, $urandom_range(0, 1) == 1);
            run_load("random", b, 4);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[$];
        sel = 1'b1;
        do_reset();
        b = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
        run_load("overflow", b, 2);
        test_post_done();
        sel = 1'b0;
    endtask

`ifdef IMEM_LOADER_CKSUM_EN
    task automatic test_checksum();
        logic [7:0] b[$];
        sel = 1'b0;
        do_reset();
        b = {8'h12, 8'h34, 8'hFF, 8'hFF, 8'h26};
        run_load("cksum_good", b, 1);
        do_reset();
        b = {8'h12, 8'h34, 8'hFF, 8'hFF, 8'h27};
        run_load("cksum_bad", b, 1);
    endtask
`endif

    task automatic test_mid_reset();
        logic [7:0] b[$];
        bit ok;
        sel = 1'b0;
        do_reset();
        send_byte(8'h55, 0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (!ok || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: got ok=%b busy=%b want 1 1", ok, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({in_ready, we, waddr, wdata, busy, done, err, cpu_run} !== 30'd0) begin
            n_err++;
            $display("FAIL mid_reset_values: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b run=%b want all 0",
                     in_ready, we, waddr, wdata, busy, done, err, cpu_run);
        end
        rst_n = 1'b1;
        got_q.delete();
        we_t.delete();
        ready_in_wr = 0;
        b = {8'h00, 8'h07, 8'hFF, 8'hFF};
        add_cksum(b, 1'b0);
        run_load("reload", b, 2);
    endtask

    // ---------------- sequence ----------------
    initial begin
        sel      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_basic();
        test_post_done();
        test_gaps();
        test_random();
        test_overflow();
`ifdef IMEM_LOADER_CKSUM_EN
        test_checksum();
`endif
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
